// File: rtl/instruction_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_pkg
// Purpose  : Shared state and next-PC-select encodings for the fetch unit.
// Revision : 1.0
// ============================================================================
package instruction_fetch_pkg;

    localparam int INSTR_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10,
        ST_FAULT = 2'b11
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_HOLD = 2'b00,
        PC_INC  = 2'b01,
        PC_REL  = 2'b10,
        PC_REG  = 2'b11
    } pc_fs_e;

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_pc_next_logic.sv
`default_nettype none
// ============================================================================
// Module   : pc_next_logic
// Purpose  : Next-PC mux/adder with misaligned-target detection.
// Revision : 1.0
// ============================================================================
module pc_next_logic
    import instruction_fetch_pkg::*;
#(
    parameter int PC_WIDTH = 64
) (
    input  logic [PC_WIDTH-1:0] pc,
    input  logic [1:0]          pc_fs,
    input  logic [PC_WIDTH-1:0] constant,
    input  logic [PC_WIDTH-1:0] reg_data,
    output logic [PC_WIDTH-1:0] next_pc,
    output logic                misaligned
);

    logic [PC_WIDTH-1:0] w_word_offset;
    logic                w_unused_const_msbs;

    // Word offset to byte offset; the two top bits fall off the end.
    assign w_word_offset       = {constant[PC_WIDTH-3:0], 2'b00};
    assign w_unused_const_msbs = ^constant[PC_WIDTH-1:PC_WIDTH-2];

    always_comb begin
        next_pc = pc;
        case (pc_fs_e'(pc_fs))
            PC_HOLD: next_pc = pc;
            PC_INC:  next_pc = pc + PC_WIDTH'(4);
            PC_REL:  next_pc = pc + w_word_offset;
            PC_REG:  next_pc = reg_data;
        endcase
    end

    assign misaligned = |next_pc[1:0];

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch
// Purpose  : PC ownership, imem handshake and instruction hold for the core.
// Revision : 1.0
// ============================================================================
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int                PC_WIDTH = 64,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [1:0]             pc_fs,
    input  logic [PC_WIDTH-1:0]    constant,
    input  logic [PC_WIDTH-1:0]    reg_data,
    input  logic                   instr_done,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic                   instruction_valid,
    output logic [PC_WIDTH-1:0]    pc,
    output logic [PC_WIDTH-1:0]    pc_plus4,
    output logic                   fetch_fault
);

    fetch_state_e           r_state;
    logic [PC_WIDTH-1:0]    r_pc;
    logic [INSTR_WIDTH-1:0] r_instruction;
    logic                   r_valid;
    logic                   r_req;
    logic                   r_fault;

    logic [PC_WIDTH-1:0]    w_next_pc;
    logic                   w_misaligned;

    pc_next_logic #(
        .PC_WIDTH (PC_WIDTH)
    ) u_pc_next_logic (
        .pc         (r_pc),
        .pc_fs      (pc_fs),
        .constant   (constant),
        .reg_data   (reg_data),
        .next_pc    (w_next_pc),
        .misaligned (w_misaligned)
    );

    // Outputs are registered alongside the state so they change with it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_pc          <= RESET_PC;
            r_instruction <= '0;
            r_valid       <= 1'b0;
            r_req         <= 1'b0;
            r_fault       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_FETCH;
                    r_req   <= 1'b1;
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        r_instruction <= imem_rdata;
                        r_req         <= 1'b0;
                        r_valid       <= 1'b1;
                        r_state       <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (instr_done) begin
                        r_valid <= 1'b0;
                        if (w_misaligned) begin
                            r_fault <= 1'b1;
                            r_state <= ST_FAULT;
                        end else begin
                            r_pc    <= w_next_pc;
                            r_req   <= 1'b1;
                            r_state <= ST_FETCH;
                        end
                    end
                end
                ST_FAULT: begin
                    r_state <= ST_FAULT;
                end
            endcase
        end
    end

    assign imem_req          = r_req;
    assign imem_addr         = r_pc;
    assign instruction       = r_instruction;
    assign instruction_valid = r_valid;
    assign pc                = r_pc;
    assign pc_plus4          = r_pc + PC_WIDTH'(4);
    assign fetch_fault       = r_fault;

endmodule
`default_nettype wire

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Supplies the 32-bit instruction word consumed by the control unit. Owns the program counter, runs the instruction-memory request/acknowledge handshake, and holds the instruction stable across multi-cycle execution until the datapath signals completion. Computes the next PC from the control word's PC-select field, the 64-bit constant and register data, and flags misaligned targets.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset; must be 4-byte aligned.
PC_WIDTH, 64, width of PC, constant and register-data paths.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
pc_fs  input  2  next-PC select: 00 hold/refetch, 01 PC+4, 10 PC+(constant<<2), 11 reg_data
constant  input  PC_WIDTH  sign-extended word offset from the control unit
reg_data  input  PC_WIDTH  register-file read value for BR
instr_done  input  1  last execution cycle of the current instruction (control-unit state returning to 0)
imem_req  output  1  memory fetch request
imem_addr  output  PC_WIDTH  fetch address (equals pc)
imem_ack  input  1  memory has valid data this cycle
imem_rdata  input  32  fetched instruction word
instruction  output  32  registered instruction to the control unit
instruction_valid  output  1  instruction is current and executing
pc  output  PC_WIDTH  address of the current instruction
pc_plus4  output  PC_WIDTH  pc+4, combinational, used for BL link
fetch_fault  output  1  sticky misaligned-target flag

Behaviour:
- Reset values (asynchronous, take effect immediately): state=IDLE, pc=RESET_PC, instruction=0, instruction_valid=0, imem_req=0, fetch_fault=0.
- FSM states and outputs:
  - IDLE: all outputs at reset values; next cycle goes to FETCH.
  - FETCH: imem_req=1, imem_addr=pc. When imem_ack=1, capture imem_rdata into instruction and go to EXEC. Otherwise stay; req and address stay stable until ack.
  - EXEC: instruction_valid=1, imem_req=0. When instr_done=1, compute next PC and go to FETCH; on a fault, go to FAULT instead.
  - FAULT: instruction_valid=0, imem_req=0, fetch_fault=1, pc frozen. Exits only via reset.
- Latency: with imem_ack in the first FETCH cycle, instruction_valid rises on the following edge. Minimum instruction period is 2 cycles (FETCH, EXEC); the first instruction is valid 2 cycles after reset release.
- Next PC, evaluated only in EXEC with instr_done=1:
  - 00: pc unchanged; the same address is refetched.
  - 01: pc+4.
  - 10: pc+(constant<<2).
  - 11: reg_data.
- Arithmetic: all sums are modulo 2^PC_WIDTH (wrap-around, no flag). constant<<2 discards the top 2 bits.
- Alignment: if next_pc[1:0]!=0, pc is not updated; the FSM goes to FAULT and fetch_fault is set. Only pc_fs=11 can produce this.
- instruction_valid drops for at least one cycle (FETCH) between consecutive instructions.
- Ignored inputs:
  - imem_ack outside FETCH.
  - imem_rdata without imem_ack.
  - instr_done outside EXEC.
  - pc_fs, constant and reg_data except in the instr_done cycle.
- Ack and instr_done in the same cycle: only the input relevant to the current state acts.
- Reset mid-fetch: imem_req drops immediately; any late ack after release is ignored because the FSM is in IDLE.
- pc_plus4 is combinational from the registered pc, with no added latency.

Decomposition:
- Shared package: FSM state encoding (IDLE, FETCH, EXEC, FAULT, 2 bits); PC_FS encodings (PC_HOLD, PC_INC, PC_REL, PC_REG); the instruction width constant 32.
- One sub-module, pc_next_logic: combinational mux/adder producing next_pc and misaligned from pc, pc_fs, constant and reg_data. The FSM and registers stay in instruction_fetch.

Test Plan:
- Reset release, RESET_PC=0, ack on first FETCH cycle with rdata=32'h8B020020 -> imem_req high 1 cycle after release with addr=0; instruction=32'h8B020020 and instruction_valid=1 on the next edge.
- Ack delayed 3 cycles -> imem_req and imem_addr held stable for 4 cycles; instruction_valid stays 0 until the edge after ack.
- pc=0x100, instr_done with pc_fs=10, constant=-2 (all-ones…FE) -> next imem_addr=0xF8. pc_fs=01 at pc=64'hFFFFFFFFFFFFFFFC -> next addr=0 (wrap).
- pc=0x40, instr_done with pc_fs=11, reg_data=0x1002 -> fetch_fault=1, pc stays 0x40, no further imem_req; reset clears fault and restarts at RESET_PC.
- Multi-cycle: instr_done low for 3 EXEC cycles with pc_fs toggling -> instruction stable, pc unchanged; on instr_done with pc_fs=00 -> refetch at the same address.
- Reset asserted while in FETCH with ack pending -> imem_req=0 immediately; ack asserted 1 cycle after release is ignored; first fetch proceeds normally.
